// File: rtl/apb_pkg.sv
// Shared types and constants for the APB register-file slave.
package apb_pkg;

    // Bus-side controller states
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } apb_state_t;

    // Command codes used by APB masters driving this slave
    typedef enum logic [1:0] {
        CMD_NOP = 2'b00,
        CMD_R   = 2'b01,
        CMD_W   = 2'b10
    } apb_cmd_t;

    localparam logic [31:0] ID_VALUE   = 32'hA9B0_0001;

    // Byte offsets of the read-only registers with the default 16-register window
    localparam logic [31:0] CNT_OFFSET = 32'h0000_0038;
    localparam logic [31:0] ID_OFFSET  = 32'h0000_003C;

    localparam int WAIT_W = 4;

endpackage

// File: rtl/apb_slave_regbank.sv
// Register storage, address decode and access checks for the APB slave.
// The last two indices are the read-only transaction counter and ID word.
import apb_pkg::*;

module apb_slave_regbank #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1100,
    parameter int          NUM_REGS  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] word_addr,
    input  logic        write,
    input  logic [31:0] wdata,
    input  logic        complete,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int                IDX_W   = $clog2(NUM_REGS);
    localparam int                NUM_RW  = NUM_REGS - 2;
    localparam logic [IDX_W-1:0]  CNT_IDX = IDX_W'(NUM_REGS - 2);
    localparam logic [IDX_W-1:0]  ID_IDX  = IDX_W'(NUM_REGS - 1);

    logic [31:0]      regs [NUM_RW];
    logic [31:0]      txn_cnt;
    logic [29:0]      word_off;
    logic             in_win;
    logic [IDX_W-1:0] idx;
    logic             is_ro;
    logic             do_write;
    logic             do_count;

    // Decode the latched word address into a window check and register index.
    // Addresses below the base wrap to large offsets and fall outside the window.
    always_comb begin
        word_off = word_addr - BASE_ADDR[31:2];
        in_win   = word_off < 30'(NUM_REGS);
        idx      = word_off[IDX_W-1:0];
        is_ro    = idx >= CNT_IDX;
        err      = !in_win || (write && is_ro);
        do_write = complete && !err && write;
        do_count = complete && !err;
    end

    // Read mux; out-of-window reads return zero
    always_comb begin
        rdata = 32'h0;
        if (in_win) begin
            if (idx == ID_IDX)
                rdata = ID_VALUE;
            else if (idx == CNT_IDX)
                rdata = txn_cnt;
            else
                rdata = regs[idx];
        end
    end

    // Register writes and transaction counting happen on the completion edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_RW; i++)
                regs[i] <= 32'h0;
            txn_cnt <= 32'h0;
        end else begin
            if (do_write)
                regs[idx] <= wdata;
            if (do_count)
                txn_cnt <= txn_cnt + 32'h1;
        end
    end

endmodule

// File: rtl/apb_slave_regfile.sv
// APB slave front end: setup/access sequencing with a programmable number
// of wait states. PREADY is decoded purely from registered state.
import apb_pkg::*;

module apb_slave_regfile #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1100,
    parameter int          NUM_REGS    = 16,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic        PREADY,
    output logic [31:0] PRDATA,
    output logic        PSLVERR
);

    apb_state_t        state;
    apb_state_t        next_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [29:0]       addr_q;
    logic              write_q;
    logic [31:0]       wdata_q;
    logic              ready;
    logic              complete;
    logic [31:0]       bank_rdata;
    logic              bank_err;
    logic              unused_addr_lsbs;

    // Byte-lane bits carry no meaning for a word-only register bank
    assign unused_addr_lsbs = ^PADDR[1:0];

    // State register
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    // Next-state logic; an access with PENABLE but no setup is ignored in IDLE
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (PSEL && !PENABLE)
                    next_state = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (!PSEL)
                    next_state = ST_IDLE;
                else if (PENABLE && (wait_cnt == '0))
                    next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Output decode; read data and error are only driven during the ready cycle
    always_comb begin
        ready    = (state == ST_ACCESS) && (wait_cnt == '0);
        complete = ready && PSEL && PENABLE;
        PREADY   = ready;
        PSLVERR  = ready && bank_err;
        PRDATA   = (ready && !write_q && !bank_err) ? bank_rdata : 32'h0;
    end

    // Latch the transfer at setup and count down wait states during access
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            wait_cnt <= '0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            wdata_q  <= 32'h0;
        end else if (state == ST_IDLE && PSEL && !PENABLE) begin
            wait_cnt <= WAIT_W'(WAIT_CYCLES);
            addr_q   <= PADDR[31:2];
            write_q  <= PWRITE;
            wdata_q  <= PWDATA;
        end else if (state == ST_ACCESS && PSEL && PENABLE && wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 1'b1;
        end
    end

    apb_slave_regbank #(
        .BASE_ADDR (BASE_ADDR),
        .NUM_REGS  (NUM_REGS)
    ) u_regbank (
        .clk       (PCLK),
        .rst       (PRESET),
        .word_addr (addr_q),
        .write     (write_q),
        .wdata     (wdata_q),
        .complete  (complete),
        .rdata     (bank_rdata),
        .err       (bank_err)
    );

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: two instances (one and zero wait states)
// share the bus except for PSEL, checked every cycle against a register model.
import apb_pkg::*;

module tb_apb_slave_regfile;

    localparam logic [31:0] BASE = 32'h0000_1100;
    localparam int          NR   = 16;

    logic        clk;
    logic        rst;
    logic [1:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        pready  [2];
    logic [31:0] prdata  [2];
    logic        pslverr [2];

    logic        exp_ready [2];
    logic [31:0] exp_rdata [2];
    logic        exp_err   [2];

    logic [31:0] mem  [2][NR];
    logic [31:0] tcnt [2];

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] got_rd;
    logic        got_err;

    apb_slave_regfile #(.BASE_ADDR(BASE), .NUM_REGS(NR), .WAIT_CYCLES(1)) dut0 (
        .PCLK(clk), .PRESET(rst), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PREADY(pready[0]), .PRDATA(prdata[0]),
        .PSLVERR(pslverr[0])
    );

    apb_slave_regfile #(.BASE_ADDR(BASE), .NUM_REGS(NR), .WAIT_CYCLES(0)) dut1 (
        .PCLK(clk), .PRESET(rst), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PREADY(pready[1]), .PRDATA(prdata[1]),
        .PSLVERR(pslverr[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Every-cycle compare of both instances against the model's expectations
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            check32($sformatf("pready[%0d]", d), {31'b0, pready[d]}, {31'b0, exp_ready[d]});
            check32($sformatf("prdata[%0d]", d), prdata[d], exp_rdata[d]);
            check32($sformatf("pslverr[%0d]", d), {31'b0, pslverr[d]}, {31'b0, exp_err[d]});
        end
    end

    task automatic exp_quiet();
        for (int d = 0; d < 2; d++) begin
            exp_ready[d] = 1'b0;
            exp_rdata[d] = 32'h0;
            exp_err[d]   = 1'b0;
        end
    endtask

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            tcnt[d] = 32'h0;
            for (int i = 0; i < NR; i++) mem[d][i] = 32'h0;
        end
    endtask

    // What the slave must answer for an access, from the register map alone
    task automatic predict(input int d, input logic wr, input logic [31:0] a,
                           output logic err, output logic [31:0] data, output int idx);
        logic [31:0] al;
        al   = {a[31:2], 2'b00};
        err  = 1'b1;
        data = 32'h0;
        idx  = -1;
        if (al >= BASE && al < BASE + 4 * NR) begin
            idx = int'((al - BASE) / 4);
            if (idx == NR - 1) begin
                err  = wr;
                data = 32'hA9B0_0001;
            end else if (idx == NR - 2) begin
                err  = wr;
                data = tcnt[d];
            end else begin
                err  = 1'b0;
                data = mem[d][idx];
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic en);
        psel    = 2'b00;
        penable = en;
        if (en) psel[0] = 1'b1;
        exp_quiet();
        repeat (n) cyc();
        psel    = 2'b00;
        penable = 1'b0;
    endtask

    // One transfer on instance d; abort_at >= 0 drops PSEL in that access cycle
    task automatic xfer(input int d, input apb_cmd_t cmd, input logic [31:0] a,
                        input logic [31:0] wd, input int abort_at,
                        output logic [31:0] rd, output logic e);
        int          w;
        int          idx;
        logic        wr;
        logic        perr;
        logic [31:0] pdata;
        logic        aborted;
        w       = (d == 0) ? 1 : 0;
        wr      = (cmd == CMD_W);
        aborted = 1'b0;
        rd      = 32'h0;
        e       = 1'b0;
        predict(d, wr, a, perr, pdata, idx);
        psel    = 2'b00;
        psel[d] = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = a;
        pwdata  = wd;
        exp_quiet();
        cyc();
        for (int k = 0; k <= w; k++) begin
            penable = 1'b1;
            if (k == abort_at) psel[d] = 1'b0;
            exp_ready[d] = (k == w);
            exp_err[d]   = (k == w) && perr;
            exp_rdata[d] = (k == w && !wr && !perr) ? pdata : 32'h0;
            @(negedge clk);
            if (k == w) begin
                rd = prdata[d];
                e  = pslverr[d];
            end
            cyc();
            if (k == abort_at) begin
                aborted = 1'b1;
                break;
            end
        end
        if (!aborted && !perr) begin
            if (wr) mem[d][idx] = wd;
            tcnt[d] = tcnt[d] + 32'h1;
        end
        psel    = 2'b00;
        penable = 1'b0;
        exp_quiet();
    endtask

    initial begin
        rst     = 1'b1;
        psel    = 2'b00;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 32'h0;
        pwdata  = 32'h0;
        exp_quiet();
        model_clear();
        repeat (3) cyc();
        rst = 1'b0;

        // Zero-wait instance: ID read, three writes, counter reads, RO write
        xfer(1, CMD_R, BASE + ID_OFFSET, 32'h0, -1, got_rd, got_err);
        check32("id_read_w0", got_rd, 32'hA9B0_0001);
        xfer(1, CMD_W, 32'h0000_1100, 32'h1111_0000, -1, got_rd, got_err);
        xfer(1, CMD_W, 32'h0000_1104, 32'h2222_0000, -1, got_rd, got_err);
        xfer(1, CMD_W, 32'h0000_1108, 32'h3333_0000, -1, got_rd, got_err);
        xfer(1, CMD_R, BASE + CNT_OFFSET, 32'h0, -1, got_rd, got_err);
        check32("cnt_after_4", got_rd, 32'h0000_0004);
        xfer(1, CMD_W, BASE + CNT_OFFSET, 32'hFFFF_0000, -1, got_rd, got_err);
        check32("ro_write_err", {31'b0, got_err}, 32'h1);
        xfer(1, CMD_R, BASE + CNT_OFFSET, 32'h0, -1, got_rd, got_err);
        check32("cnt_after_ro_write", got_rd, 32'h0000_0005);
        xfer(1, CMD_R, 32'h0000_1104, 32'h0, -1, got_rd, got_err);
        check32("w0_rw_readback", got_rd, 32'h2222_0000);

        // One-wait instance
        xfer(0, CMD_W, 32'h0000_1104, 32'h0000_EEEE, -1, got_rd, got_err);
        check32("wr1104_err", {31'b0, got_err}, 32'h0);
        xfer(0, CMD_R, 32'h0000_1104, 32'h0, -1, got_rd, got_err);
        check32("rd1104", got_rd, 32'h0000_EEEE);
        xfer(0, CMD_W, 32'h0000_2000, 32'h5555_5555, -1, got_rd, got_err);
        check32("oow_write_err", {31'b0, got_err}, 32'h1);
        check32("oow_write_rdata", got_rd, 32'h0);
        xfer(0, CMD_R, 32'h0000_1104, 32'h0, -1, got_rd, got_err);
        check32("rd1104_after_oow", got_rd, 32'h0000_EEEE);
        xfer(0, CMD_W, 32'h0000_1100, 32'h0000_DDDD, -1, got_rd, got_err);
        xfer(0, CMD_R, 32'h0000_1100, 32'h0, -1, got_rd, got_err);
        check32("b2b_read", got_rd, 32'h0000_DDDD);
        idle(1, 1'b0);
        xfer(0, CMD_W, 32'h0000_1108, 32'h7777_7777, 0, got_rd, got_err);
        idle(3, 1'b1);
        xfer(0, CMD_R, 32'h0000_1108, 32'h0, -1, got_rd, got_err);
        check32("rd1108_after_abort", got_rd, 32'h0);
        xfer(0, CMD_R, 32'h0000_1106, 32'h0, -1, got_rd, got_err);
        check32("addr_lsbs_ignored", got_rd, 32'h0000_EEEE);
        xfer(0, CMD_R, 32'h0000_1000, 32'h0, -1, got_rd, got_err);
        check32("below_base_err", {31'b0, got_err}, 32'h1);
        xfer(0, CMD_R, BASE + CNT_OFFSET, 32'h0, -1, got_rd, got_err);
        check32("cnt_w1", got_rd, 32'h0000_0007);

        // Reset asserted in the middle of an access
        psel    = 2'b01;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 32'h0000_1108;
        pwdata  = 32'h1234_5678;
        exp_quiet();
        cyc();
        penable = 1'b1;
        #1 rst = 1'b1;
        #1;
        check32("rst_pready", {31'b0, pready[0]}, 32'h0);
        check32("rst_prdata", prdata[0], 32'h0);
        check32("rst_pslverr", {31'b0, pslverr[0]}, 32'h0);
        cyc();
        psel    = 2'b00;
        penable = 1'b0;
        rst     = 1'b0;
        model_clear();
        xfer(0, CMD_R, BASE + CNT_OFFSET, 32'h0, -1, got_rd, got_err);
        check32("cnt_after_reset", got_rd, 32'h0);
        xfer(0, CMD_R, 32'h0000_1104, 32'h0, -1, got_rd, got_err);
        check32("rd1104_after_reset", got_rd, 32'h0);
        xfer(0, CMD_R, 32'h0000_1108, 32'h0, -1, got_rd, got_err);
        check32("rd1108_after_reset", got_rd, 32'h0);
        xfer(1, CMD_R, 32'h0000_1100, 32'h0, -1, got_rd, got_err);
        check32("w0_cleared", got_rd, 32'h0);
        idle(2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_slave_regfile.md
APB_SLAVE_REGFILE -- requirements
Module: apb_slave_regfile

Interface
REQ-001 SHALL use parameter BASE_ADDR, default 32'h0000_1100, byte address of register 0.
REQ-002 SHALL use parameter NUM_REGS, default 16, count of 32-bit registers; window = BASE_ADDR .. BASE_ADDR+4*NUM_REGS-1.
REQ-003 SHALL use parameter WAIT_CYCLES, default 1, PREADY-low access cycles inserted per transfer (0..15).
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 PCLK  input  1  clock; all state updates on rising edge.
REQ-006 PRESET  input  1  asynchronous reset, active-high.
REQ-007 PSEL  input  1  slave select from APB master.
REQ-008 PENABLE  input  1  access-phase indicator.
REQ-009 PWRITE  input  1  1 = write, 0 = read.
REQ-010 PADDR  input  32  byte address; PADDR[1:0] ignored.
REQ-011 PWDATA  input  32  write data.
REQ-012 PREADY  output  1  transfer completion.
REQ-013 PRDATA  output  32  read data; valid only while PREADY=1 on a read, else 0.
REQ-014 PSLVERR  output  1  error flag; valid only while PREADY=1, else 0.

Function
REQ-015 SHALL implement FSM states IDLE and ACCESS.
REQ-016 IDLE: PSEL=1 & PENABLE=0 (setup phase) -> ACCESS; latch PADDR, PWRITE, PWDATA; load wait counter with WAIT_CYCLES.
REQ-017 IDLE: PENABLE=1 without prior setup -> ignored, stay IDLE, PREADY=0.
REQ-018 ACCESS: PREADY = (wait counter == 0), decoded from registered state only; no combinational path from inputs to PREADY.
REQ-019 ACCESS, PSEL=1, PENABLE=1, counter != 0 -> decrement counter, stay ACCESS.
REQ-020 ACCESS, PSEL=1, PENABLE=1, counter == 0 -> transfer completes this edge: write committed, -> IDLE; PREADY=1 for exactly one cycle.
REQ-021 WAIT_CYCLES=0 -> PREADY=1 in first access cycle (two-cycle transfer); WAIT_CYCLES=N -> N+2 cycles setup to completion.
REQ-022 ACCESS, PSEL=0 (master abort) -> -> IDLE, no write, transaction counter unchanged.
REQ-023 Register index = (latched PADDR - BASE_ADDR) >> 2.
REQ-024 Indices 0..NUM_REGS-3: read/write, 32-bit, no byte strobes.
REQ-025 Index NUM_REGS-2 (0x38 offset at default): read-only transaction counter, +1 per completed error-free transfer, wraps 32'hFFFF_FFFF -> 0.
REQ-026 Index NUM_REGS-1 (0x3C offset): read-only ID = 32'hA9B0_0001.
REQ-027 Address outside window -> PSLVERR=1, PRDATA=0, write dropped, counter unchanged.
REQ-028 Write to read-only index -> PSLVERR=1, no state change, counter unchanged.
REQ-029 Read returns register value at completion edge, including a write completed in the immediately preceding transfer.
REQ-030 Back-to-back transfers: setup in the cycle after completion SHALL be accepted with no idle cycle.

Reset
REQ-031 PRESET=1 SHALL force, asynchronously: state IDLE, wait counter 0, all RW registers 0, transaction counter 0, PREADY=0, PRDATA=0, PSLVERR=0.
REQ-032 Reset during ACCESS SHALL abort the transfer with no write committed.
REQ-033 Deassertion SHALL take effect at next PCLK edge; first setup accepted in that cycle.

Structure
REQ-034 Package apb_pkg SHALL hold: FSM state enum, ID constant, counter/ID register offsets, APB master command codes (NOP=2'b00, R=2'b01, W=2'b10).
REQ-035 Register storage, decode, and RO/RW/error checks SHALL live in sub-module apb_slave_regbank; FSM and wait counter in apb_slave_regfile.

Verification
REQ-036 Write 32'h0000_EEEE to 32'h0000_1104, WAIT_CYCLES=1 -> PREADY low 1 access cycle then high 1 cycle, PSLVERR=0; read 0x1104 -> PRDATA=32'h0000_EEEE.
REQ-037 WAIT_CYCLES=0, read 32'h0000_113C -> PREADY=1 in first access cycle, PRDATA=32'hA9B0_0001.
REQ-038 Three completed writes then read 0x1138 -> PRDATA=32'h0000_0003; write 0x1138 -> PSLVERR=1, value unchanged.
REQ-039 Write to 32'h0000_2000 -> PSLVERR=1, PRDATA=0, no register modified.
REQ-040 PSEL dropped during wait cycles of write to 0x1108 -> FSM IDLE, 0x1108 still 0; PRESET pulse mid-ACCESS -> all outputs 0, registers cleared.
REQ-041 Back-to-back write 0x1100 = 32'h0000_DDDD then read 0x1100 with no idle cycle -> read returns 32'h0000_DDDD.
